// File: rtl/fetch_unit.sv
// Instruction fetch stage. Keeps one instruction-memory request in flight,
// buffers the returned instructions with their PCs in a small FIFO and
// presents them over valid/ready. A redirect flushes everything and restarts
// fetch at a new word-aligned address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        fetch_pc_q;
  logic [31:0]        req_pc_q;
  logic [31:0]        instr_mem [FIFO_DEPTH];
  logic [31:0]        pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic issue;
  logic push;
  logic pop;

  // Request handshake and FIFO strobes; redirect cancels issue, push and pop.
  assign imem_req  = (state_q == S_IDLE) && (count_q < CNT_W'(FIFO_DEPTH)) && !redirect && !rst;
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;
  assign push      = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign pop       = if_valid && if_ready && !redirect;

  // FIFO head presentation.
  assign if_valid = (count_q != '0);
  assign if_instr = instr_mem[rd_ptr_q];
  assign if_pc    = pc_mem[rd_ptr_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: track whether the outstanding response is kept or dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch PC and the PC of the request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
    end else if (issue) begin
      fetch_pc_q <= fetch_pc_q + 32'd4;
      req_pc_q   <= fetch_pc_q;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  // FIFO pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Occupancy can never exceed the buffer size.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(FIFO_DEPTH))
        else $error("fetch_unit: FIFO occupancy %0d exceeds depth", count_q);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder drives the imem side,
// a reference model predicts request behaviour and the expected instruction
// stream, and a monitor compares the DUT against it every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int tests = 0;
  int fails = 0;
  int delivered = 0;

  // Reference model state.
  ent_t        exp_q[$];
  logic [31:0] m_pc = RPC;
  logic [31:0] m_req_pc = '0;
  bit          m_out = 1'b0;
  bit          m_keep = 1'b0;
  bit          m_rst_last = 1'b0;
  bit          started = 1'b0;
  bit          req_this = 1'b0;

  // Memory responder state.
  bit          s_req = 1'b0;
  logic [31:0] s_addr = '0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_delay = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9B13;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare request side and FIFO head against the model mid-cycle.
  always @(negedge clk) begin
    bit exp_req;
    exp_req = 1'b0;
    if (started) begin
      exp_req = !m_out && (exp_q.size() < DEPTH) && !redirect && !rst;
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      if (m_rst_last) begin
        check("reset_if_pc", if_pc, 32'h0);
        check("reset_if_instr", if_instr, 32'h0);
        check("reset_imem_addr", imem_addr, RPC);
      end
      if (exp_q.size() != 0 && if_ready && !redirect && !rst) begin
        check("if_pc", if_pc, exp_q[0].pc);
        check("if_instr", if_instr, exp_q[0].instr);
        void'(exp_q.pop_front());
        delivered++;
      end
    end
    req_this = exp_req;
    s_req    = imem_req;
    s_addr   = imem_addr;
  end

  // Reference model: advance fetch/flush/buffer rules at each clock edge.
  always @(posedge clk) begin
    m_rst_last = rst;
    if (rst) begin
      started = 1'b1;
      m_out   = 1'b0;
      m_keep  = 1'b0;
      m_pc    = RPC;
      exp_q.delete();
    end else if (started) begin
      if (redirect) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        exp_q.delete();
        if (m_out) begin
          if (imem_rvalid) m_out = 1'b0;
          else m_keep = 1'b0;
        end
      end else begin
        if (m_out && imem_rvalid) begin
          if (m_keep) exp_q.push_back('{pc: m_req_pc, instr: instr_of(m_req_pc)});
          m_out = 1'b0;
        end
        if (req_this && imem_gnt) begin
          m_out    = 1'b1;
          m_keep   = 1'b1;
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  end

  // One cycle of stimulus: memory responder plus random consumer/redirect/reset.
  task automatic step(input int p_gnt, input int p_ready, input int p_redir,
                      input int p_rst, input int max_delay);
    logic [31:0] rp;
    @(posedge clk);
    #1;
    if (imem_rvalid) mem_busy = 1'b0;
    if (s_req && imem_gnt) begin
      mem_busy  = 1'b1;
      mem_addr  = s_addr;
      mem_delay = int'($urandom_range(max_delay, 0));
    end
    imem_rvalid = 1'b0;
    if (mem_busy) begin
      if (mem_delay == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(mem_addr);
      end else begin
        mem_delay--;
      end
    end
    imem_gnt = !mem_busy && (int'($urandom_range(99, 0)) < p_gnt);
    if_ready = (int'($urandom_range(99, 0)) < p_ready);
    redirect = (int'($urandom_range(99, 0)) < p_redir);
    rp = $urandom;
    if ($urandom_range(3, 0) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
    redirect_pc = rp;
    rst = (int'($urandom_range(99, 0)) < p_rst);
  endtask

  task automatic run_phase(input int n, input int p_gnt, input int p_ready,
                           input int p_redir, input int p_rst, input int max_delay);
    for (int i = 0; i < n; i++) step(p_gnt, p_ready, p_redir, p_rst, max_delay);
  endtask

  initial begin
    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if_ready    = 1'b0;
    repeat (2) @(posedge clk);
    // Sequential fetch, then backpressure and release.
    run_phase(40, 100, 100, 0, 0, 0);
    run_phase(20, 100, 0, 0, 0, 0);
    run_phase(20, 100, 100, 0, 0, 0);
    // Grant stalls.
    run_phase(80, 20, 100, 0, 0, 1);
    // Frequent redirects with late responses.
    run_phase(300, 70, 60, 15, 0, 3);
    // Reset pulses mid-operation.
    run_phase(300, 70, 60, 8, 5, 3);
    // Mixed traffic.
    run_phase(1500, 60, 70, 4, 1, 3);
    // Drain quietly.
    run_phase(20, 100, 100, 0, 0, 0);
    check("delivered_enough", 32'(delivered > 100), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the core's decode/execute logic. It owns the fetch PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs in a small FIFO. The FIFO is presented to the consumer over a valid/ready interface. A redirect input (taken branch or jump) flushes everything in flight and restarts fetch at a new address.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  request valid
- imem_addr  out  32  request address, word-aligned
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 00
- if_valid  out  1  buffered instruction available
- if_instr  out  32  instruction at FIFO head
- if_pc  out  32  PC of if_instr
- if_ready  in  1  consumer takes the head entry when if_valid=1

## Operation
- Registers:
  - fetch_pc: next address to request.
  - req_pc: PC of the outstanding request.
  - state.
  - FIFO: storage, read/write pointers, count 0..FIFO_DEPTH.
- States:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding; its response will be kept.
  - DROP: one request outstanding; its response will be discarded.
- Request issue:
  - imem_req = (state==IDLE) && (count < FIFO_DEPTH) && !redirect && !rst.
  - imem_addr = fetch_pc.
- IDLE:
  - imem_req && imem_gnt → WAIT, req_pc <= fetch_pc, fetch_pc <= fetch_pc+4.
  - imem_rvalid in IDLE is ignored.
- WAIT:
  - imem_rvalid → push {imem_rdata, req_pc}, go to IDLE.
  - redirect without rvalid → DROP.
  - redirect with rvalid in the same cycle → response discarded, go to IDLE.
- DROP:
  - imem_rvalid → discard, go to IDLE.
  - A further redirect stays in DROP and updates fetch_pc.
- Redirect (any state):
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - FIFO count and pointers cleared; a simultaneous pop or push is cancelled.
- Pop: if_valid && if_ready && !redirect.
  - Push and pop in the same cycle leave count unchanged.
- Overflow cannot occur: at most one request is outstanding, and a request is issued only when count < FIFO_DEPTH.
  - The RTL includes an assertion (simulation only) that count never exceeds FIFO_DEPTH.
- fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Outputs:
  - if_valid = (count != 0).
  - if_instr/if_pc come from storage at the read pointer.

## Timing
- Reset (rst=1 at a posedge), values after that edge:
  - state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0.
  - FIFO storage and req_pc are cleared to 0.
  - Outputs: imem_req=0 while rst=1, if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC.
- First request: imem_req=1 in the first cycle with rst=0.
- Handshake rules:
  - imem_req and imem_addr stay stable until imem_gnt.
  - Exception: a redirect withdraws imem_req for that cycle, and the address changes on the next cycle.
  - The memory treats a withdrawn, ungranted request as cancelled.
- Latency:
  - rvalid can come no earlier than the cycle after gnt.
  - A pushed entry shows on if_valid the cycle after the push (registered FIFO).
  - Peak throughput is one instruction per 2 cycles.
- Reset mid-operation:
  - Any outstanding request is abandoned; the state returns to IDLE.
  - A late rvalid is ignored by the IDLE rule.

## Test plan
- Sequential fetch:
  - Stimulus: rst high 2 cycles then low; imem_gnt=1; rvalid one cycle after each gnt with rdata=addr|32'h13; if_ready=1.
  - Response: first if_valid=1 in cycle 2 after reset release, with if_pc=0, if_instr=32'h13. Then if_pc=4, 8, 12… every 2 cycles.
- Backpressure:
  - Stimulus: if_ready=0.
  - Response: after PCs 0 and 4 are buffered (count=2), imem_req stays 0. Raising if_ready delivers 0, 4, 8 in order, with no loss or duplication.
- Grant stall:
  - Stimulus: imem_gnt low 4 cycles.
  - Response: imem_req=1 and imem_addr=0 stay constant throughout; one request is issued on the gnt.
- Redirect in WAIT:
  - Stimulus: rvalid delayed 3 cycles; redirect=1 with redirect_pc=32'h103 on the cycle after the gnt.
  - Response: the late response is dropped. The next request uses addr 32'h100, and the next if_pc is 32'h100.
- Redirect collisions:
  - Stimulus: redirect in the same cycle as rvalid, and in a cycle with if_valid && if_ready.
  - Response: the response is not pushed, if_valid=0 the next cycle, and no entry is popped twice.
- Reset mid-WAIT:
  - Stimulus: rst pulsed one cycle while in WAIT, then rvalid arrives 1 cycle after release.
  - Response: the stale data is ignored, and the first delivered instruction has if_pc=RESET_PC.
